// File: rtl/vdp_vga_timing.sv
// 640x480@60 raster generator with SMS line numbering and frame/line interrupts.
// Optional build macro VDP_LINE_IRQ_EN adds the reloadable line counter and line interrupt.
module vdp_vga_timing #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ACT_ROW0 = 48
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       frameIE,
    input  logic       lineIE,
    input  logic [7:0] lineReload,
    input  logic       status_rd,
    output logic [9:0] col,
    output logic [8:0] row,
    output logic [7:0] vcount,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       frameFlag,
    output logic       lineFlag,
    output logic       INT_L
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] ACT      = 10'(ACT_ROW0);
    // SMS line 192 (frame interrupt line) is 384 doubled rows into the window.
    localparam logic [9:0] WIN_END  = 10'(ACT_ROW0 + 384);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [9:0] hNext;
    logic [9:0] vNext;
    logic [9:0] rowOffset;
    logic [8:0] smsLine;
    logic       atCol0;
    logic       pairStart;
    logic       lineTick;
    logic       inWindow;
    logic       reloadRow;
    logic       frameSet;
    logic       lineTerm;

    always_comb begin
        hNext     = (hcnt == H_LAST) ? 10'd0 : hcnt + 10'd1;
        vNext     = vcnt;
        if (hcnt == H_LAST) begin
            vNext = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end
        rowOffset = vcnt - ACT;
        atCol0    = (hcnt == 10'd0);
        pairStart = ~rowOffset[0];
        lineTick  = atCol0 && (vcnt >= ACT) && pairStart;
        inWindow  = (vcnt >= ACT) && (vcnt <= WIN_END);
        reloadRow = (vcnt < ACT) || (vcnt > WIN_END + 10'd1);
        frameSet  = atCol0 && (vcnt == WIN_END);
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            hcnt      <= 10'd0;
            vcnt      <= 10'd0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            smsLine   <= 9'd0;
            frameFlag <= 1'b0;
            INT_L     <= 1'b1;
        end else begin
            hcnt      <= hNext;
            vcnt      <= vNext;
            VGA_HS    <= ~((hNext >= HS_START) && (hNext <= HS_END));
            VGA_VS    <= ~((vNext >= VS_START) && (vNext <= VS_END));
            // One SMS line per doubled row pair, both inside and outside the window.
            if (atCol0 && (vcnt == ACT)) begin
                smsLine <= 9'd0;
            end else if (atCol0 && pairStart) begin
                smsLine <= smsLine + 9'd1;
            end
            frameFlag <= frameSet | (frameFlag & ~status_rd);
            INT_L     <= ~((frameFlag & frameIE) | lineTerm);
        end
    end

`ifdef VDP_LINE_IRQ_EN
    logic [7:0] lc;
    logic       lineReg;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            lc      <= 8'hFF;
            lineReg <= 1'b0;
        end else begin
            if (lineTick && inWindow) begin
                lc <= (lc == 8'd0) ? lineReload : lc - 8'd1;
            end else if (atCol0 && reloadRow) begin
                lc <= lineReload;
            end
            lineReg <= (lineTick && inWindow && (lc == 8'd0)) | (lineReg & ~status_rd);
        end
    end

    assign lineTerm = lineReg & lineIE;
`else
    logic lineReg;
    logic unusedLine;

    assign lineReg    = 1'b0;
    assign lineTerm   = 1'b0;
    assign unusedLine = ^{lineIE, lineReload, lineTick, inWindow, reloadRow};
`endif

    logic unusedSms;
    assign unusedSms = smsLine[8];

    assign col      = hcnt;
    assign row      = vcnt[8:0];
    assign vcount   = smsLine[7:0];
    assign lineFlag = lineReg;

endmodule

// File: tb/tb_vdp_vga_timing.sv
// Randomized bench for vdp_vga_timing against a position-based reference model.
// Uses a shortened horizontal line so whole frames fit in a short run.
module tb_vdp_vga_timing;
    localparam int HV  = 20;
    localparam int HF  = 4;
    localparam int HSW = 6;
    localparam int HB  = 5;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = 525;
    localparam int HS0 = HV + HF;
    localparam int HS1 = HV + HF + HSW - 1;

    logic       clk = 1'b0;
    logic       rst_L;
    logic       frameIE;
    logic       lineIE;
    logic [7:0] lineReload;
    logic       status_rd;
    logic [9:0] col;
    logic [8:0] row;
    logic [7:0] vcount;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       frameFlag;
    logic       lineFlag;
    logic       INT_L;

    vdp_vga_timing #(
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_VIS(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .ACT_ROW0(48)
    ) dut (
        .clk(clk), .rst_L(rst_L), .frameIE(frameIE), .lineIE(lineIE),
        .lineReload(lineReload), .status_rd(status_rd),
        .col(col), .row(row), .vcount(vcount), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .frameFlag(frameFlag), .lineFlag(lineFlag), .INT_L(INT_L)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: position, cycles since reset release, flags, latched reload.
    int mC, mR, mT, frameNo, mRel, vsLow;
    bit mFrame, mLine, mInt;

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0d expected %0d (row %0d col %0d)", tag, got, exp, mR, mC);
        end
    endtask

    // SMS line expected from raster position alone.
    function automatic int smsExp(input int c, input int r, input int t);
        int e;
        if (t == 0) return 0;
        e = (c >= 1) ? r : (r + VT - 1) % VT;
        if (t < 48 * HT + 1) return e / 2 + 1;
        if (e >= 48) return (e - 48) / 2;
        return 239 + e / 2;
    endfunction

    task automatic modelReset();
        mC = 0; mR = 0; mT = 0; vsLow = 0;
        mFrame = 0; mLine = 0; mInt = 1;
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, ".col"}, col, 0);
        checkVal({tag, ".row"}, row, 0);
        checkVal({tag, ".hs"}, VGA_HS, 1);
        checkVal({tag, ".vs"}, VGA_VS, 1);
        checkVal({tag, ".vcount"}, vcount, 0);
        checkVal({tag, ".frameFlag"}, frameFlag, 0);
        checkVal({tag, ".lineFlag"}, lineFlag, 0);
        checkVal({tag, ".INT_L"}, INT_L, 1);
    endtask

    task automatic stepCycle();
        bit tickWin, nFrame, nLine, nInt, forced;
        int k;
        forced    = 0;
        status_rd = ($urandom_range(0, 39) == 0);
        if (frameNo == 1 && mC == 0 && mR == 432) begin
            status_rd = 1'b1;
            forced    = 1;
        end
        if ($urandom_range(0, 799) == 0) frameIE = ~frameIE;
        if ($urandom_range(0, 799) == 0) lineIE = ~lineIE;
        if (mC == 5 && mR == 10) begin
            if (frameNo == 0) lineReload = 8'd3;
            else if (frameNo == 1) lineReload = 8'd0;
            else lineReload = 8'($urandom_range(0, 255));
        end

        if (mC == 0 && mR == 47) mRel = lineReload;
        tickWin = (mC == 0) && (mR >= 48) && (mR <= 432) && ((mR - 48) % 2 == 0);
        k       = (mR - 48) / 2;
        nFrame  = (mC == 0 && mR == 432) || (mFrame && !status_rd);
`ifdef VDP_LINE_IRQ_EN
        nLine   = (tickWin && ((k + 1) % (mRel + 1) == 0)) || (mLine && !status_rd);
        nInt    = !((mFrame && frameIE) || (mLine && lineIE));
`else
        nLine   = 0;
        nInt    = !(mFrame && frameIE);
`endif
        mFrame = nFrame; mLine = nLine; mInt = nInt;
        mC++; mT++;
        if (mC == HT) begin
            mC = 0;
            mR++;
            if (mR == VT) begin
                mR = 0;
                frameNo++;
            end
        end

        @(posedge clk);
        #1;
        checkVal("col", col, mC);
        checkVal("row", row, mR % 512);
        checkVal("hs", VGA_HS, (mC >= HS0 && mC <= HS1) ? 0 : 1);
        checkVal("vs", VGA_VS, (mR == 490 || mR == 491) ? 0 : 1);
        checkVal("vcount", vcount, smsExp(mC, mR, mT) % 256);
        checkVal("frameFlag", frameFlag, mFrame);
        checkVal("lineFlag", lineFlag, mLine);
        checkVal("INT_L", INT_L, mInt);
        if (forced) checkVal("setWinsOverClear", frameFlag, 1);
        if (VGA_VS == 1'b0) vsLow++;
        if (mC == 0 && mR == 0) begin
            checkVal("vsLowPerFrame", vsLow, 2 * HT);
            vsLow = 0;
        end
    endtask

    initial begin
        int guard;
        rst_L      = 1'b0;
        frameIE    = 1'b1;
        lineIE     = 1'b1;
        lineReload = 8'd3;
        status_rd  = 1'b0;
        frameNo    = 0;
        mRel       = 255;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        @(negedge clk);
        rst_L = 1'b1;

        guard = 0;
        while (!(frameNo == 2 && mR == 200 && mC == 20) && guard < 60000) begin
            stepCycle();
            guard++;
        end
        checkVal("reachMidFrame", guard < 60000, 1);

        // Asynchronous reset between clock edges.
        #1;
        rst_L = 1'b0;
        #1;
        checkReset("asyncReset");
        status_rd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_L = 1'b1;
        modelReset();
        stepCycle();
        checkVal("colAfterRelease", col, 1);
        repeat (450 * HT) stepCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
